scan_decoder: RTL and testbench

Parametrised, registered binary-to-one-hot decoder. It is the sequential successor to the team's combinational 3-to-8 decoder. Two modes:
- DIRECT: decodes a loaded select value.
- SCAN: autonomously walks the one-hot output across N_OUT lines, holding each for DWELL cycles.

Intended use is digit/row strobing for multiplexed displays and keypads, and as a general address-to-line decoder.

---
 rtl/scan_decoder.sv | 121 ++++++++++++
 tb/tb_scan_decoder.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/scan_decoder.sv
// Registered binary-to-one-hot decoder with a direct-load mode and an
// autonomous scanning mode for display/keypad strobing.
module scan_decoder #(
   parameter int unsigned SEL_W      = 3,
   parameter int unsigned N_OUT      = 8,
   parameter int unsigned DWELL      = 4,
   parameter bit          ACTIVE_LOW = 1'b0
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             Enable,
   input  logic             Mode,
   input  logic             Load,
   input  logic [SEL_W-1:0] Data_in,
   output logic [N_OUT-1:0] Data_out,
   output logic [SEL_W-1:0] Index,
   output logic             Valid,
   output logic             Wrap,
   output logic             Range_err
);

   localparam int unsigned      CNT_W     = (DWELL > 1) ? $clog2(DWELL) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DWELL - 1);
   localparam logic [SEL_W-1:0] IDX_LAST  = SEL_W'(N_OUT - 1);
   // One extra bit so N_OUT == 2**SEL_W is representable.
   localparam logic [SEL_W:0]   N_OUT_EXT = (SEL_W + 1)'(N_OUT);
   localparam logic [N_OUT-1:0] LINE0     = N_OUT'(1);

   typedef enum logic [1:0] {StIdle, StDirect, StScan} state_e;

   state_e           state_q, state_d;
   logic [SEL_W-1:0] idx_q, idx_d;
   logic [N_OUT-1:0] hot_q, hot_d;     // active-high one-hot, before polarity
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             valid_q, valid_d;
   logic             wrap_q, wrap_d;
   logic             rerr_q, rerr_d;

   // Next-state and next-output decode for all three operating states.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      hot_d   = hot_q;
      cnt_d   = cnt_q;
      valid_d = valid_q;
      wrap_d  = 1'b0;
      rerr_d  = 1'b0;

      if (!Enable) begin
         state_d = StIdle;
         hot_d   = '0;
         valid_d = 1'b0;
         cnt_d   = '0;
      end else if (!Mode) begin
         state_d = StDirect;
         cnt_d   = '0;
         if (Load) begin
            if ({1'b0, Data_in} < N_OUT_EXT) begin
               idx_d   = Data_in;
               hot_d   = LINE0 << Data_in;
               valid_d = 1'b1;
            end else begin
               hot_d   = '0;
               valid_d = 1'b0;
               rerr_d  = 1'b1;
            end
         end
      end else begin
         state_d = StScan;
         valid_d = 1'b1;
         if (state_q != StScan) begin
            // Fresh entry always restarts at line 0 without a wrap pulse.
            idx_d = '0;
            hot_d = LINE0;
            cnt_d = '0;
         end else if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            if (idx_q == IDX_LAST) begin
               idx_d  = '0;
               wrap_d = 1'b1;
            end else begin
               idx_d = idx_q + SEL_W'(1);
            end
            hot_d = LINE0 << idx_d;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q <= StIdle;
         idx_q   <= '0;
         hot_q   <= '0;
         cnt_q   <= '0;
         valid_q <= 1'b0;
         wrap_q  <= 1'b0;
         rerr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         hot_q   <= hot_d;
         cnt_q   <= cnt_d;
         valid_q <= valid_d;
         wrap_q  <= wrap_d;
         rerr_q  <= rerr_d;
      end
   end

   // Polarity applied only at the pins; internal logic is always active-high.
   always_comb begin
      Data_out  = ACTIVE_LOW ? ~hot_q : hot_q;
      Index     = idx_q;
      Valid     = valid_q;
      Wrap      = wrap_q;
      Range_err = rerr_q;
   end

endmodule

// File: tb/tb_scan_decoder.sv
// Bench for scan_decoder: three instances (default, N_OUT=6/DWELL=1/active-low,
// default active-low) share one stimulus stream and are each compared every
// cycle against a cycle-position based reference model.
module tb_scan_decoder;

   logic       Clk = 1'b0;
   logic       Reset, Enable, Mode, Load;
   logic [2:0] Data_in;

   logic [7:0] a_out;  logic [2:0] a_idx;  logic a_val, a_wrap, a_rerr;
   logic [5:0] b_out;  logic [2:0] b_idx;  logic b_val, b_wrap, b_rerr;
   logic [7:0] c_out;  logic [2:0] c_idx;  logic c_val, c_wrap, c_rerr;

   int n_assert = 0;
   int n_fail   = 0;

   always #5 Clk = ~Clk;

   scan_decoder #(.SEL_W(3), .N_OUT(8), .DWELL(4), .ACTIVE_LOW(1'b0)) dut_a (
      .Clk(Clk), .Reset(Reset), .Enable(Enable), .Mode(Mode), .Load(Load),
      .Data_in(Data_in), .Data_out(a_out), .Index(a_idx), .Valid(a_val),
      .Wrap(a_wrap), .Range_err(a_rerr)
   );

   scan_decoder #(.SEL_W(3), .N_OUT(6), .DWELL(1), .ACTIVE_LOW(1'b1)) dut_b (
      .Clk(Clk), .Reset(Reset), .Enable(Enable), .Mode(Mode), .Load(Load),
      .Data_in(Data_in), .Data_out(b_out), .Index(b_idx), .Valid(b_val),
      .Wrap(b_wrap), .Range_err(b_rerr)
   );

   scan_decoder #(.SEL_W(3), .N_OUT(8), .DWELL(4), .ACTIVE_LOW(1'b1)) dut_c (
      .Clk(Clk), .Reset(Reset), .Enable(Enable), .Mode(Mode), .Load(Load),
      .Data_in(Data_in), .Data_out(c_out), .Index(c_idx), .Valid(c_val),
      .Wrap(c_wrap), .Range_err(c_rerr)
   );

   // st: 0 idle, 1 direct, 2 scan. t counts cycles since scan entry.
   typedef struct {
      int n; int dwell; int al;
      int st; int idx; int on; int valid; int wrap; int rerr; int t;
   } model_t;

   model_t ma, mb, mc;

   function automatic model_t mk(int n, int dwell, int al);
      model_t m;
      m = '{n: n, dwell: dwell, al: al, default: 0};
      return m;
   endfunction

   function automatic model_t step(model_t m, logic r, logic en, logic md, logic ld, int din);
      m.wrap = 0;
      m.rerr = 0;
      if (r) begin
         m.st = 0; m.idx = 0; m.on = 0; m.valid = 0; m.t = 0;
      end else if (!en) begin
         m.st = 0; m.on = 0; m.valid = 0;
      end else if (!md) begin
         m.st = 1;
         if (ld) begin
            if (din < m.n) begin
               m.idx = din; m.on = 1; m.valid = 1;
            end else begin
               m.on = 0; m.valid = 0; m.rerr = 1;
            end
         end
      end else begin
         m.t     = (m.st == 2) ? m.t + 1 : 0;
         m.st    = 2;
         m.idx   = (m.t / m.dwell) % m.n;
         m.on    = 1;
         m.valid = 1;
         m.wrap  = (m.t > 0 && (m.t % (m.dwell * m.n)) == 0) ? 1 : 0;
      end
      return m;
   endfunction

   function automatic logic [31:0] exp_out(model_t m);
      int v;
      v = m.on ? (1 << m.idx) : 0;
      if (m.al != 0) v = ~v & ((1 << m.n) - 1);
      return 32'(v);
   endfunction

   task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic check_all();
      check("a.data",  32'(a_out),  exp_out(ma));
      check("a.index", 32'(a_idx),  32'(ma.idx));
      check("a.valid", 32'(a_val),  32'(ma.valid));
      check("a.wrap",  32'(a_wrap), 32'(ma.wrap));
      check("a.rerr",  32'(a_rerr), 32'(ma.rerr));
      check("b.data",  32'(b_out),  exp_out(mb));
      check("b.index", 32'(b_idx),  32'(mb.idx));
      check("b.valid", 32'(b_val),  32'(mb.valid));
      check("b.wrap",  32'(b_wrap), 32'(mb.wrap));
      check("b.rerr",  32'(b_rerr), 32'(mb.rerr));
      check("c.data",  32'(c_out),  exp_out(mc));
      check("c.index", 32'(c_idx),  32'(mc.idx));
      check("c.valid", 32'(c_val),  32'(mc.valid));
      check("c.wrap",  32'(c_wrap), 32'(mc.wrap));
      check("c.rerr",  32'(c_rerr), 32'(mc.rerr));
   endtask

   // One clock: drive, advance models on the edge, check 1 time unit later.
   task automatic cycle(logic r, logic en, logic md, logic ld, int din);
      Reset = r; Enable = en; Mode = md; Load = ld; Data_in = 3'(din);
      @(posedge Clk);
      ma = step(ma, r, en, md, ld, din);
      mb = step(mb, r, en, md, ld, din);
      mc = step(mc, r, en, md, ld, din);
      #1;
      check_all();
   endtask

   initial begin
      int wraps;
      int wrap_at;
      logic r, en, md, ld;

      ma = mk(8, 4, 0);
      mb = mk(6, 1, 1);
      mc = mk(8, 4, 1);
      Reset = 1'b1; Enable = 1'b1; Mode = 1'b1; Load = 1'b0; Data_in = '0;

      // Reset held three cycles with scan requested, then released.
      for (int i = 0; i < 3; i++) cycle(1, 1, 1, 0, 0);
      check("rst.a_data", 32'(a_out), 32'h00);
      check("rst.c_data", 32'(c_out), 32'hFF);
      cycle(0, 1, 1, 0, 0);
      check("rst.line0", 32'(a_out), 32'h01);

      // Direct sweep of all select values on consecutive cycles.
      for (int d = 0; d < 8; d++) begin
         cycle(0, 1, 0, 1, d);
         check("sweep.a_data", 32'(a_out), 32'(1 << d));
         check("sweep.c_data", 32'(c_out), 32'(~(1 << d) & 8'hFF));
      end

      // Out-of-range load on the 6-line instance, then a legal one.
      cycle(0, 1, 0, 1, 6);
      check("oor.b_rerr", 32'(b_rerr), 32'd1);
      check("oor.b_data", 32'(b_out), 32'h3F);
      cycle(0, 1, 0, 1, 5);
      check("oor.b_rerr_clear", 32'(b_rerr), 32'd0);
      check("oor.b_data5", 32'(b_out), 32'h1F);

      // Scan for 40 cycles from direct mode; wrap expected once, at cycle 33.
      wraps = 0; wrap_at = 0;
      for (int i = 1; i <= 40; i++) begin
         cycle(0, 1, 1, 0, 0);
         if (a_wrap) begin wraps++; wrap_at = i; end
      end
      check("scan.wrap_count", 32'(wraps), 32'd1);
      check("scan.wrap_cycle", 32'(wrap_at), 32'd33);

      // Interruptions: stop mid-scan at line 3, return to scan, disable, reset.
      cycle(0, 0, 1, 0, 0);
      for (int i = 0; i < 13; i++) cycle(0, 1, 1, 0, 0);
      check("int.at3", 32'(a_idx), 32'd3);
      for (int i = 0; i < 3; i++) cycle(0, 1, 0, 0, 0);
      check("int.hold08", 32'(a_out), 32'h08);
      cycle(0, 1, 1, 0, 0);
      check("int.restart", 32'(a_out), 32'h01);
      cycle(0, 0, 1, 0, 0);
      check("int.blank", 32'(a_out), 32'h00);
      check("int.invalid", 32'(a_val), 32'd0);
      for (int i = 0; i < 6; i++) cycle(0, 1, 1, 0, 0);
      cycle(1, 1, 1, 0, 0);
      check("int.reset_idx", 32'(a_idx), 32'd0);
      // Load in the scan-to-direct switching cycle must be honoured.
      for (int i = 0; i < 9; i++) cycle(0, 1, 1, 0, 0);
      cycle(0, 1, 0, 1, 6);
      check("int.switch_load", 32'(a_out), 32'h40);

      // Randomized phase with sticky mode and occasional reset/disable.
      md = 1'b0;
      for (int i = 0; i < 800; i++) begin
         r  = ($urandom_range(0, 59) == 0);
         en = ($urandom_range(0, 11) != 0);
         if ($urandom_range(0, 14) == 0) md = ~md;
         ld = $urandom_range(0, 1) == 1;
         cycle(r, en, md, ld, int'($urandom_range(0, 7)));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
